// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 decrypt engine.
//   arc4_state_e  - engine FSM state encoding
//   S_DEPTH       - depth of the permutation array
//   PRINT_LO/HI   - printable ASCII window used by the optional plaintext check
//   is_printable  - helper testing a byte against that window
package arc4_pkg;

  localparam int S_DEPTH = 256;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RI,
    ST_KSA_RJ,
    ST_KSA_WI,
    ST_KSA_WJ,
    ST_LEN_RD,
    ST_LEN_LAT,
    ST_LEN_WR,
    ST_P_RI,
    ST_P_RJ,
    ST_P_WI,
    ST_P_WJ,
    ST_P_RP,
    ST_P_XOR,
    ST_P_WR,
    ST_DONE
  } arc4_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/arc4_engine_if.sv
// arc4_engine_if: job handshake plus CT-read / PT-write memory ports.
//   en, key       - start request and key (master -> engine)
//   rdy           - engine idle / able to accept en
//   ct_addr       - CT read address; ct_rddata valid one cycle later
//   pt_addr, pt_wrdata, pt_wren - PT write port, one byte per strobe
//   pt_bad        - sticky non-printable plaintext flag
interface arc4_engine_if #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_AW    = 8
);

  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [MSG_AW-1:0]      ct_addr;
  logic [7:0]             ct_rddata;
  logic [MSG_AW-1:0]      pt_addr;
  logic [7:0]             pt_wrdata;
  logic                   pt_wren;
  logic                   pt_bad;

  modport master (
    output en, key, ct_rddata,
    input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, pt_bad
  );

  modport slave (
    input  en, key, ct_rddata,
    output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, pt_bad
  );

endinterface

// File: rtl/arc4_sram256.sv
// arc4_sram256: 256x8 array, one write and one synchronous read per cycle.
//   clk   - clock
//   we    - write enable for waddr/wdata
//   raddr - read address; rdata valid the following cycle (old data on a
//           same-address read/write collision)
module arc4_sram256
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [S_DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/arc4_engine.sv
// arc4_engine: ARC4 decrypt of a length-prefixed CT buffer into a
// length-prefixed PT buffer, S array held in arc4_sram256.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - arc4_engine_if slave: en/rdy/key handshake, CT read, PT write,
//          pt_bad flag
// Optional: define ARC4_PRINT_CHECK_EN to build the sticky non-printable
// plaintext detector driving pt_bad; otherwise pt_bad is tied low.
module arc4_engine
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MSG_AW    = 8
) (
  input logic          clk,
  input logic          rst,
  arc4_engine_if.slave bus
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_BYTES - 1);
  localparam logic [7:0] LEN_MAX = (MSG_AW >= 8) ? 8'hFF : 8'((1 << MSG_AW) - 1);

  arc4_state_e state_q, state_d;

  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [7:0]             i_q, i_d, j_q, j_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d, ct_q, ct_d;
  logic [MSG_AW-1:0]      k_q, k_d, len_q, len_d;
  logic [MSG_AW-1:0]      ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d;
  logic [7:0]             pt_wrdata_q, pt_wrdata_d;

  logic       s_we;
  logic [7:0] s_waddr, s_wdata, s_raddr, s_rdata;
  logic [7:0] key_arr [KEY_BYTES];
  logic [7:0] key_byte, len_sat, pad_out;
  logic       rdy, accept;

  arc4_sram256 u_sram (
    .clk   (clk),
    .we    (s_we),
    .waddr (s_waddr),
    .wdata (s_wdata),
    .raddr (s_raddr),
    .rdata (s_rdata)
  );

  // Key byte 0 is the most significant byte of the key port.
  always_comb begin
    for (int unsigned n = 0; n < KEY_BYTES; n++) begin
      key_arr[n] = key_q[8*(KEY_BYTES-1-n) +: 8];
    end
  end

  // DONE is the first cycle with rdy high and accepts a job exactly as IDLE.
  assign rdy      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept   = rdy && bus.en;
  assign key_byte = key_arr[kidx_q];
  assign len_sat  = (bus.ct_rddata > LEN_MAX) ? LEN_MAX : bus.ct_rddata;
  assign pad_out  = s_rdata ^ ct_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      kidx_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ct_q        <= '0;
      k_q         <= '0;
      len_q       <= '0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      kidx_q      <= kidx_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ct_q        <= ct_d;
      k_q         <= k_d;
      len_q       <= len_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    kidx_d      = kidx_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    ct_d        = ct_q;
    k_d         = k_q;
    len_d       = len_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    s_we        = 1'b0;
    s_waddr     = i_q;
    s_wdata     = i_q;
    s_raddr     = i_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.en) begin
          key_d   = bus.key;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        s_we    = 1'b1;
        s_waddr = i_q;
        s_wdata = i_q;
        i_d     = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d     = '0;
          kidx_d  = '0;
          state_d = ST_KSA_RI;
        end
      end
      ST_KSA_RI: begin
        s_raddr = i_q;
        state_d = ST_KSA_RJ;
      end
      ST_KSA_RJ: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata + key_byte;
        s_raddr = j_d;
        state_d = ST_KSA_WI;
      end
      ST_KSA_WI: begin
        s_we    = 1'b1;
        s_waddr = i_q;
        s_wdata = s_rdata;
        state_d = ST_KSA_WJ;
      end
      ST_KSA_WJ: begin
        s_we    = 1'b1;
        s_waddr = j_q;
        s_wdata = si_q;
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
        if (i_q == 8'hFF) begin
          ct_addr_d = '0;
          state_d   = ST_LEN_RD;
        end else begin
          state_d   = ST_KSA_RI;
        end
      end
      ST_LEN_RD: begin
        state_d = ST_LEN_LAT;
      end
      ST_LEN_LAT: begin
        len_d       = MSG_AW'(len_sat);
        pt_addr_d   = '0;
        pt_wrdata_d = len_sat;
        i_d         = '0;
        j_d         = '0;
        k_d         = MSG_AW'(1);
        state_d     = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        state_d = (len_q == '0) ? ST_DONE : ST_P_RI;
      end
      ST_P_RI: begin
        i_d       = i_q + 8'd1;
        s_raddr   = i_d;
        ct_addr_d = k_q;
        state_d   = ST_P_RJ;
      end
      ST_P_RJ: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        s_raddr = j_d;
        state_d = ST_P_WI;
      end
      ST_P_WI: begin
        sj_d    = s_rdata;
        ct_d    = bus.ct_rddata;
        s_we    = 1'b1;
        s_waddr = i_q;
        s_wdata = s_rdata;
        state_d = ST_P_WJ;
      end
      ST_P_WJ: begin
        s_we    = 1'b1;
        s_waddr = j_q;
        s_wdata = si_q;
        state_d = ST_P_RP;
      end
      // Pad read waits until the swap has landed: S[si+sj] may alias S[j].
      ST_P_RP: begin
        s_raddr = si_q + sj_q;
        state_d = ST_P_XOR;
      end
      ST_P_XOR: begin
        pt_addr_d   = k_q;
        pt_wrdata_d = pad_out;
        state_d     = ST_P_WR;
      end
      ST_P_WR: begin
        k_d     = k_q + 1'b1;
        state_d = (k_q == len_q) ? ST_DONE : ST_P_RI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rdy       = rdy;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = (state_q == ST_LEN_WR) || (state_q == ST_P_WR);

`ifdef ARC4_PRINT_CHECK_EN
  logic pt_bad_q, pt_bad_d;

  // Judged on the byte being latched for PT, so the flag is current by the
  // time rdy rises after the final write.
  always_comb begin
    pt_bad_d = pt_bad_q;
    if (accept) begin
      pt_bad_d = 1'b0;
    end else if ((state_q == ST_P_XOR) && !is_printable(pad_out)) begin
      pt_bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pt_bad_q <= 1'b0;
    else     pt_bad_q <= pt_bad_d;
  end

  assign bus.pt_bad = pt_bad_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.pt_bad    = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_engine.sv
// tb_arc4_engine: three engines (3-, 4- and 6-byte keys) driven with known
// ARC4 vectors and random jobs; results checked against a behavioural
// RC4 model, PT write count, latency bound and pt_bad.
module tb_arc4_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arc4_engine_if #(.KEY_BYTES(3), .MSG_AW(8)) if3 ();
  arc4_engine_if #(.KEY_BYTES(4), .MSG_AW(8)) if4 ();
  arc4_engine_if #(.KEY_BYTES(6), .MSG_AW(8)) if6 ();

  arc4_engine #(.KEY_BYTES(3), .MSG_AW(8)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  arc4_engine #(.KEY_BYTES(4), .MSG_AW(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  arc4_engine #(.KEY_BYTES(6), .MSG_AW(8)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  logic        en_v    [3];
  logic [47:0] key_v   [3];
  logic [7:0]  ct_rd_v [3];
  logic        rdy_v   [3];
  logic        wren_v  [3];
  logic        bad_v   [3];
  logic [7:0]  ct_addr_v [3];
  logic [7:0]  pt_addr_v [3];
  logic [7:0]  pt_data_v [3];

  assign if3.en = en_v[0];
  assign if4.en = en_v[1];
  assign if6.en = en_v[2];
  assign if3.key = key_v[0][23:0];
  assign if4.key = key_v[1][31:0];
  assign if6.key = key_v[2];
  assign if3.ct_rddata = ct_rd_v[0];
  assign if4.ct_rddata = ct_rd_v[1];
  assign if6.ct_rddata = ct_rd_v[2];

  assign rdy_v[0] = if3.rdy;  assign rdy_v[1] = if4.rdy;  assign rdy_v[2] = if6.rdy;
  assign wren_v[0] = if3.pt_wren;  assign wren_v[1] = if4.pt_wren;  assign wren_v[2] = if6.pt_wren;
  assign bad_v[0] = if3.pt_bad;  assign bad_v[1] = if4.pt_bad;  assign bad_v[2] = if6.pt_bad;
  assign ct_addr_v[0] = if3.ct_addr;  assign ct_addr_v[1] = if4.ct_addr;  assign ct_addr_v[2] = if6.ct_addr;
  assign pt_addr_v[0] = if3.pt_addr;  assign pt_addr_v[1] = if4.pt_addr;  assign pt_addr_v[2] = if6.pt_addr;
  assign pt_data_v[0] = if3.pt_wrdata;  assign pt_data_v[1] = if4.pt_wrdata;  assign pt_data_v[2] = if6.pt_wrdata;

  // CT / PT memories per engine
  logic [7:0] ct_mem [3][256];
  logic [7:0] pt_mem [3][256];
  int         wr_cnt [3];
  int         stray  [3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      ct_rd_v[d] <= ct_mem[d][ct_addr_v[d]];
      if (wren_v[d]) begin
        pt_mem[d][pt_addr_v[d]] <= pt_data_v[d];
        wr_cnt[d] <= wr_cnt[d] + 1;
        if (rdy_v[d]) stray[d] <= stray[d] + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference RC4 plaintext for the CT currently in ct_mem[d]
  logic [7:0] exp_pt [256];
  int         exp_len;
  logic       exp_bad;

  function automatic void rc4_model(input int d, input int nkey, input logic [47:0] key);
    int s [256];
    int i, j, t, len;
    logic [7:0] kb;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb = 8'(key >> (8 * (nkey - 1 - (n % nkey))));
      j = (j + s[n] + int'(kb)) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(ct_mem[d][0]);
    exp_len = len;
    exp_pt[0] = 8'(len);
    exp_bad = 1'b0;
    i = 0;
    j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_pt[k] = ct_mem[d][k] ^ 8'(s[(s[i] + s[j]) % 256]);
      if (exp_pt[k] < 8'h20 || exp_pt[k] > 8'h7E) exp_bad = 1'b1;
    end
  endfunction

  task automatic load_ct(input int d, input int n, input logic [127:0] v);
    for (int k = 0; k < n; k++) ct_mem[d][k] = v[8*(n-1-k) +: 8];
  endtask

  task automatic run_job(input int d, input int nkey, input logic [47:0] key,
                         input bit hold_en, input string name);
    int  base, cycles, bound;
    bit  done;
    rc4_model(d, nkey, key);
    base = wr_cnt[d];
    @(negedge clk);
    key_v[d] = key;
    en_v[d]  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_en) en_v[d] = 1'b0;
    check_eq({name, " busy"}, 32'(rdy_v[d]), 32'd0);
    bound  = 1284 + 7 * exp_len;
    cycles = 1;
    done   = 1'b0;
    while (!done && cycles <= bound + 20) begin
      if (rdy_v[d]) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    en_v[d] = 1'b0;
    check_eq({name, " done"}, 32'(done), 32'd1);
    check_eq($sformatf("%s latency %0d", name, cycles), 32'(cycles <= bound), 32'd1);
    check_eq({name, " wr count"}, 32'(wr_cnt[d] - base), 32'(exp_len + 1));
    for (int k = 0; k <= exp_len; k++)
      check_eq($sformatf("%s pt[%0d]", name, k), 32'(pt_mem[d][k]), 32'(exp_pt[k]));
`ifdef ARC4_PRINT_CHECK_EN
    check_eq({name, " pt_bad"}, 32'(bad_v[d]), 32'(exp_bad));
`else
    check_eq({name, " pt_bad"}, 32'(bad_v[d]), 32'd0);
`endif
    base = wr_cnt[d];
    repeat (6) @(posedge clk);
    #1;
    check_eq({name, " idle rdy"}, 32'(rdy_v[d]), 32'd1);
    check_eq({name, " idle no wr"}, 32'(wr_cnt[d] - base), 32'd0);
  endtask

  task automatic check_text(input int d, input string name, input string txt);
    for (int k = 0; k < txt.len(); k++)
      check_eq($sformatf("%s text[%0d]", name, k), 32'(pt_mem[d][k+1]), 32'(txt[k]));
  endtask

  initial begin
    int nk [3];
    logic [47:0] rkey;
    int len;
    nk[0] = 3; nk[1] = 4; nk[2] = 6;
    for (int d = 0; d < 3; d++) begin
      en_v[d]  = 1'b0;
      key_v[d] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("reset rdy%0d", d), 32'(rdy_v[d]), 32'd1);
      check_eq($sformatf("reset wren%0d", d), 32'(wren_v[d]), 32'd0);
      check_eq($sformatf("reset bad%0d", d), 32'(bad_v[d]), 32'd0);
    end

    // abort during KSA, then a clean job
    load_ct(0, 10, 128'h09BBF316E8D940AF0AD3);
    @(negedge clk);
    key_v[0] = 48'h4B6579;
    en_v[0]  = 1'b1;
    @(negedge clk);
    en_v[0]  = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort rdy", 32'(rdy_v[0]), 32'd1);
    check_eq("abort wren", 32'(wren_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // known vectors
    run_job(0, 3, 48'h4B6579, 1'b0, "key3");
    check_text(0, "key3", "Plaintext");
    load_ct(1, 6, 128'h051021BF0420);
    run_job(1, 4, 48'h57696B69, 1'b0, "wiki");
    check_text(1, "wiki", "pedia");
    load_ct(2, 15, 128'h0E45A01F645FC35B383552544B9BF5);
    run_job(2, 6, 48'h536563726574, 1'b0, "secret");
    check_text(2, "secret", "Attack at dawn");

    // empty message with en held high through the run
    ct_mem[1][0] = 8'h00;
    run_job(1, 4, 48'h57696B69, 1'b1, "len0");

    // wrong key on one byte of CT
    load_ct(0, 2, 128'h01BB);
    run_job(0, 3, 48'h000000, 1'b0, "badkey");

    // random jobs
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 3; d++) begin
        rkey = {16'($urandom), $urandom};
        len  = $urandom_range(0, 24);
        ct_mem[d][0] = 8'(len);
        for (int k = 1; k <= len; k++) ct_mem[d][k] = 8'($urandom);
        run_job(d, nk[d], rkey, r[0], $sformatf("rnd%0d_%0d", r, d));
      end
    end

    // maximum length message
    ct_mem[2][0] = 8'hFF;
    for (int k = 1; k < 256; k++) ct_mem[2][k] = 8'($urandom);
    run_job(2, 6, {16'($urandom), $urandom}, 1'b0, "maxlen");

    for (int d = 0; d < 3; d++)
      check_eq($sformatf("stray wr%0d", d), 32'(stray[d]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_engine.md
Name: arc4_engine

Overview:
- Parametrised ARC4 decrypt engine; successor to the fixed 24-bit-key ARC4 core in the board-level design.
- Reads a length-prefixed ciphertext from an external CT memory port and writes a length-prefixed plaintext to an external PT memory port.
- Holds the 256-byte S array internally.
- Generalised in key length, with restart/abort semantics. Instantiated under the board top or under a key-search wrapper.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..32); key port width 8*KEY_BYTES.
- MSG_AW, 8, CT/PT address width; max message length 2**MSG_AW - 1 (byte 0 holds the length).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  engine idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte i = key[8*(KEY_BYTES-1-i) +: 8] (MSB byte first); captured on accepted en.
- ct_addr  out  MSG_AW  CT read address.
- ct_rddata  in  8  CT read data, valid 1 cycle after ct_addr.
- pt_addr  out  MSG_AW  PT write address.
- pt_wrdata  out  8  PT write data.
- pt_wren  out  1  PT write strobe, one cycle per byte.
- pt_bad  out  1  sticky non-printable flag (ARC4_PRINT_CHECK_EN only; constant 0 otherwise).

Behaviour:
- Reset (async, any state): state=IDLE, rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0, pt_bad=0, i=j=0. The S array is not cleared. An abort mid-run leaves partially written PT contents.
- Handshake: en && rdy in cycle N accepts a job and latches key. rdy=0 from N+1 until the job completes. rdy returns to 1 the cycle after the final PT write. en while rdy=0 is ignored.
- S array: 256x8, synchronous read, 1-cycle latency, one write per cycle (BRAM-inferable).
- States:
  - IDLE: wait for accepted en.
  - INIT: S[k]=k for k=0..255; one write per cycle; 256 cycles.
  - KSA_RI → KSA_RJ → KSA_WI → KSA_WJ, per i=0..255:
    - j = j + S[i] + keybyte[i mod KEY_BYTES], all mod 256 (8-bit wrap).
    - Swap via two single writes.
  - LEN: issue ct_addr=0, wait 1 cycle, latch L=ct_rddata. Write pt[0]=L (pt_wren=1). Reset i=j=0 for PRGA.
  - PRGA per k=1..L:
    - i=i+1, j=j+S[i], swap S[i],S[j].
    - pad=S[(S[i]+S[j]) mod 256].
    - Write pt[k]=pad ^ ct[k].
    - ≤7 cycles per byte.
  - DONE: one cycle, then IDLE with rdy=1.
- L=0: only pt[0]=0 is written; the run completes after LEN.
- L > 2**MSG_AW-1 cannot occur (8-bit length with MSG_AW=8). For MSG_AW<8, L is saturated to 2**MSG_AW-1.
- i, j, and sum arithmetic are 8-bit with natural wrap; index k is MSG_AW bits.
- Key index i mod KEY_BYTES uses a separate counter that wraps at KEY_BYTES-1, not a divider.
- Total latency from accept to rdy ≤ 256 + 4*256 + 3 + 7*L + 1 cycles.
- pt_wren is never asserted outside LEN/PRGA. At most one PT write per cycle.

Optional Feature:
- Macro ARC4_PRINT_CHECK_EN.
- Defined: pt_bad is cleared on accepted en and set when any written pt[k] (k≥1) falls outside 0x20..0x7E. pt_bad remains set until the next accepted en or reset; it is valid when rdy rises. Used by the cracking wrapper to reject keys early.
- Undefined: pt_bad tied to 0 and no compare logic is generated.

Decomposition:
- Package arc4_pkg: state enum type, S_DEPTH=256, PRINT_LO=8'h20, PRINT_HI=8'h7E.
- One sub-module, arc4_sram256: 256x8 sync-read single-write array.
- The FSM and datapath stay in arc4_engine.

Test Plan:
- Reset/idle: assert rst, release → rdy=1, pt_wren=0, pt_bad=0. Pulse rst during KSA → rdy=1 next cycle; a new job then completes correctly.
- KEY_BYTES=3, key=24'h4B6579 ("Key"), CT = 09 BB F3 16 E8 D9 40 AF 0A D3 → PT = 09 "Plaintext" (50 6C 61 69 6E 74 65 78 74); rdy back within latency bound.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"), CT = 05 10 21 BF 04 20 → PT = 05 "pedia".
- KEY_BYTES=6, key="Secret", CT = 0E 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5 → PT = 0E "Attack at dawn"; with ARC4_PRINT_CHECK_EN, pt_bad=0.
- L=0 (CT[0]=00) → exactly one PT write (pt[0]=00), then rdy=1. en held high during a busy run → ignored, no second job starts.
- ARC4_PRINT_CHECK_EN, "Key" key with CT[1] flipped to 0xBA → pt[1]=0x51 is printable. Instead use CT = 01 BB with wrong key 24'h000000 → pt_bad=1 if the decrypted byte is outside 0x20..0x7E (bench computes the expected value from its reference model).
